// File: rtl/freq_meter_pkg.sv
// Shared widths, conversion FSM states and the double-dabble adjust step
// for the frequency meter.
package freq_meter_pkg;
   localparam int BIN_W       = 14;
   localparam int BCD_DIGITS  = 4;
   localparam int BCD_W       = 4 * BCD_DIGITS;
   localparam int SHIFT_STEPS = 14;

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} conv_state_t;

   // Add 3 to every nibble >= 5 so the following left shift carries correctly.
   function automatic logic [BCD_W-1:0] dabble_add3(input logic [BCD_W-1:0] bcd);
      logic [BCD_W-1:0] res;
      res = bcd;
      for (int d = 0; d < BCD_DIGITS; d++) begin
         if (bcd[4*d +: 4] >= 4'd5) res[4*d +: 4] = bcd[4*d +: 4] + 4'd3;
      end
      return res;
   endfunction
endpackage

// File: rtl/bin2bcd_seq.sv
// Serial double-dabble converter: one bit per cycle, busy from the start
// edge until the done cycle ends.
module bin2bcd_seq
   import freq_meter_pkg::*;
(
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_start,
   input  logic [BIN_W-1:0] i_bin,
   output logic             o_busy,
   output logic             o_done,
   output logic [BCD_W-1:0] o_bcd
);
   localparam int STEP_W = $clog2(SHIFT_STEPS);

   conv_state_t        r_state;
   conv_state_t        w_next;
   logic [STEP_W-1:0]  r_step;
   logic [BIN_W-1:0]   r_bin;
   logic [BCD_W-1:0]   r_bcd;
   logic [BCD_W-1:0]   w_adj;
   logic               w_last;

   assign w_adj  = dabble_add3(r_bcd);
   assign w_last = (r_step == STEP_W'(SHIFT_STEPS - 1));

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) r_state <= IDLE;
      else          r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    if (i_start) w_next = SHIFT;
         SHIFT:   if (w_last)  w_next = DONE;
         DONE:    w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   always_comb begin
      o_busy = (r_state != IDLE);
      o_done = (r_state == DONE);
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_step <= '0;
         r_bin  <= '0;
         r_bcd  <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (i_start) begin
                  r_bin  <= i_bin;
                  r_bcd  <= '0;
                  r_step <= '0;
               end
            end
            SHIFT: begin
               {r_bcd, r_bin} <= {w_adj, r_bin} << 1;
               r_step         <= r_step + STEP_W'(1);
            end
            default: ;
         endcase
      end
   end

   assign o_bcd = r_bcd;
endmodule

// File: rtl/freq_meter.sv
// Counts rising edges of an asynchronous input over a fixed gate window and
// reports the saturated count in binary and packed BCD.
module freq_meter
   import freq_meter_pkg::*;
#(
   parameter int F_CLK     = 50_000_000,
   parameter int GATE_MS   = 1000,
   parameter int MAX_COUNT = 9999
)(
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_sig,
   output logic [BIN_W-1:0] o_freq,
   output logic [BCD_W-1:0] o_bcd,
   output logic             o_ovf,
   output logic             o_valid,
   output logic             o_busy
);
   localparam int               GATE_CYCLES = F_CLK / 1000 * GATE_MS;
   localparam int               GATE_W      = $clog2(GATE_CYCLES);
   localparam logic [BIN_W-1:0] MAX_C       = BIN_W'(MAX_COUNT);

   // The converter must finish well inside one window.
   generate
      if (GATE_CYCLES < 32) begin : g_bad_gate
         $error("freq_meter: GATE_CYCLES must be at least 32");
      end
      if (MAX_COUNT > 9999) begin : g_bad_max
         $error("freq_meter: MAX_COUNT must not exceed 9999");
      end
   endgenerate

   logic              r_sync1, r_sync2, r_prev;
   logic              w_rise;
   logic [GATE_W-1:0] r_gate;
   logic              w_gate_end;
   logic [BIN_W-1:0]  r_count;
   logic              r_ovf_flag;
   logic              w_at_max;
   logic [BIN_W-1:0]  w_snap;
   logic              w_ovf_snap;
   logic [BIN_W-1:0]  r_snap;
   logic              r_ovf_snap;
   logic              w_busy, w_done;
   logic [BCD_W-1:0]  w_bcd;
   logic [BIN_W-1:0]  r_freq;
   logic [BCD_W-1:0]  r_bcd;
   logic              r_ovf, r_valid;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
         r_prev  <= 1'b0;
      end else begin
         r_sync1 <= i_sig;
         r_sync2 <= r_sync1;
         r_prev  <= r_sync2;
      end
   end

   assign w_rise     = r_sync2 & ~r_prev;
   assign w_gate_end = (r_gate == GATE_W'(GATE_CYCLES - 1));
   assign w_at_max   = (r_count == MAX_C);
   // A rise landing on the last gate cycle still belongs to this window.
   assign w_snap     = w_at_max ? MAX_C : r_count + {{(BIN_W-1){1'b0}}, w_rise};
   assign w_ovf_snap = r_ovf_flag | (w_rise & w_at_max);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)        r_gate <= '0;
      else if (w_gate_end) r_gate <= '0;
      else                 r_gate <= r_gate + GATE_W'(1);
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_count    <= '0;
         r_ovf_flag <= 1'b0;
         r_snap     <= '0;
         r_ovf_snap <= 1'b0;
      end else if (w_gate_end) begin
         r_count    <= '0;
         r_ovf_flag <= 1'b0;
         r_snap     <= w_snap;
         r_ovf_snap <= w_ovf_snap;
      end else if (w_rise) begin
         if (w_at_max) r_ovf_flag <= 1'b1;
         else          r_count    <= r_count + BIN_W'(1);
      end
   end

   bin2bcd_seq u_bcd (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_start (w_gate_end),
      .i_bin   (w_snap),
      .o_busy  (w_busy),
      .o_done  (w_done),
      .o_bcd   (w_bcd)
   );

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_freq  <= '0;
         r_bcd   <= '0;
         r_ovf   <= 1'b0;
         r_valid <= 1'b0;
      end else begin
         r_valid <= w_done;
         if (w_done) begin
            r_freq <= r_snap;
            r_bcd  <= w_bcd;
            r_ovf  <= r_ovf_snap;
         end
      end
   end

   assign o_freq  = r_freq;
   assign o_bcd   = r_bcd;
   assign o_ovf   = r_ovf;
   assign o_valid = r_valid;
   assign o_busy  = w_busy;

   a_gate_end_idle: assert property (@(posedge i_clk) disable iff (!i_rst_n) w_gate_end |-> !w_busy);
endmodule

// File: tb/tb_freq_meter.sv
// Directed bench for freq_meter: a per-window rise-count model feeds a
// scoreboard queue that is checked against every o_valid pulse.
module tb_freq_meter;
   localparam int GATE = 100;
   localparam int MAXC = 37;

   logic        clk   = 1'b0;
   logic        rst_n = 1'b0;
   logic        sig   = 1'b0;
   logic [13:0] freq;
   logic [15:0] bcd;
   logic        ovf, valid, busy;

   freq_meter #(.F_CLK(100000), .GATE_MS(1), .MAX_COUNT(MAXC)) dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .i_sig   (sig),
      .o_freq  (freq),
      .o_bcd   (bcd),
      .o_ovf   (ovf),
      .o_valid (valid),
      .o_busy  (busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      int freq;
      bit ovf;
      int cyc;
   } exp_t;

   exp_t sb[$];
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;
   int   win_cnt [0:63];
   int   next_w = 1;
   bit   prev_v = 1'b0;
   bit   push_en = 1'b1;
   int   hold_freq = 0;
   int   hold_bcd = 0;
   bit   hold_ovf = 1'b0;

   // Edges since reset release: after edge j, cyc == j.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) cyc <= 0;
      else        cyc <= cyc + 1;
   end

   function automatic int to_bcd(input int v);
      return ((v / 1000 % 10) << 12) | ((v / 100 % 10) << 8) | ((v / 10 % 10) << 4) | (v % 10);
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Drive one cycle of i_sig; a rise driven before edge n is counted at edge n+2.
   task automatic step(input logic v);
      int n, w;
      exp_t e;
      @(negedge clk);
      sig = v;
      n = cyc + 1;
      if (v && !prev_v) begin
         w = (n + 1) / GATE + 1;
         win_cnt[w]++;
      end
      prev_v = v;
      if (push_en && n == GATE * next_w - 2) begin
         e.freq = (win_cnt[next_w] > MAXC) ? MAXC : win_cnt[next_w];
         e.ovf  = (win_cnt[next_w] > MAXC);
         e.cyc  = GATE * next_w + 15;
         sb.push_back(e);
         next_w++;
      end
   endtask

   task automatic model_reset();
      sig    = 1'b0;
      prev_v = 1'b0;
      sb.delete();
      foreach (win_cnt[i]) win_cnt[i] = 0;
      next_w    = 1;
      hold_freq = 0;
      hold_bcd  = 0;
      hold_ovf  = 1'b0;
   endtask

   always @(posedge clk) begin : mon
      exp_t e;
      #1;
      chk("busy", 32'(busy), 32'(cyc >= GATE && cyc % GATE < 15));
      if (valid === 1'b1) begin
         chk("valid_expected", 32'(sb.size() != 0), 32'd1);
         if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("valid_cycle", cyc, e.cyc);
            chk("freq", 32'(freq), e.freq);
            chk("bcd", 32'(bcd), to_bcd(e.freq));
            chk("ovf", 32'(ovf), 32'(e.ovf));
            hold_freq = e.freq;
            hold_bcd  = to_bcd(e.freq);
            hold_ovf  = e.ovf;
         end
      end else begin
         chk("freq_hold", 32'(freq), hold_freq);
         chk("bcd_hold", 32'(bcd), hold_bcd);
         chk("ovf_hold", 32'(ovf), 32'(hold_ovf));
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int ph;
      foreach (win_cnt[i]) win_cnt[i] = 0;
      repeat (3) @(negedge clk);
      chk("rst_freq", 32'(freq), 32'd0);
      chk("rst_bcd", 32'(bcd), 32'd0);
      chk("rst_ovf", 32'(ovf), 32'd0);
      chk("rst_valid", 32'(valid), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      rst_n = 1'b1;

      // constant low, then period 10, period 2 (saturates), back to period 10
      repeat (200) step(1'b0);
      for (int i = 0; i < 300; i++) step(logic'((i / 5) % 2));
      for (int i = 0; i < 200; i++) step(logic'(i % 2));
      for (int i = 0; i < 200; i++) step(logic'((i / 5) % 2));

      // single rise counted exactly at the gate-end edge
      do step(1'b0); while (cyc % GATE != 96);
      repeat (100) step(1'b0);
      repeat (3) step(1'b1);
      // same rise one cycle later lands in the following window
      do step(1'b0); while (cyc % GATE != 97);
      repeat (100) step(1'b0);
      repeat (3) step(1'b1);
      repeat (150) step(1'b0);

      // reset in the middle of a conversion
      for (int i = 0; i < 100; i++) step(logic'((i / 5) % 2));
      ph = 100;
      do begin
         step(logic'((ph / 5) % 2));
         ph++;
      end while (cyc % GATE != 7);
      rst_n = 1'b0;
      model_reset();
      #1;
      chk("midrst_freq", 32'(freq), 32'd0);
      chk("midrst_bcd", 32'(bcd), 32'd0);
      chk("midrst_ovf", 32'(ovf), 32'd0);
      chk("midrst_valid", 32'(valid), 32'd0);
      chk("midrst_busy", 32'(busy), 32'd0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 250; i++) step(logic'((i / 5) % 2));

      push_en = 1'b0;
      while (cyc < GATE * (next_w - 1) + 20) step(1'b0);
      chk("sb_drained", sb.size(), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
